// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller.
package counter_ctrl_pkg;

  localparam int unsigned COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between a host and counter_ctrl.
interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] value;
  logic             tick;
  logic             busy;
  logic             err;

  modport master (
    output start, stop, pause, periodic, limit,
    input  value, tick, busy, err
  );

  modport slave (
    input  start, stop, pause, periodic, limit,
    output value, tick, busy, err
  );
endinterface

// File: rtl/counter_ctrl_count_core.sv
// Registered counter datapath: clear has priority over increment.
module count_core
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (en) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Start/stop/pause controller around a single count_core instance.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  counter_ctrl_if.slave   bus
);

  state_t           state, state_n;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic [WIDTH-1:0] value;
  logic             tick_q, err_q, busy_q;
  logic             clr, en, load, tick_n, err_n;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .value (value)
  );

  // A paused-then-released HOLD counts on the release edge, same as RUN.
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    tick_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.limit != '0) begin
            state_n = ST_RUN;
            clr     = 1'b1;
            load    = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_RUN, ST_HOLD: begin
        if (bus.stop) begin
          state_n = ST_IDLE;
          clr     = 1'b1;
        end else if (bus.pause) begin
          state_n = ST_HOLD;
        end else if (value == limit_q) begin
          clr     = 1'b1;
          tick_n  = 1'b1;
          state_n = periodic_q ? ST_RUN : ST_IDLE;
        end else begin
          en      = 1'b1;
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_IDLE;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state  <= state_n;
      tick_q <= tick_n;
      err_q  <= err_n;
      busy_q <= is_active(state_n);
      if (load) begin
        limit_q    <= bus.limit;
        periodic_q <= bus.periodic;
      end
    end
  end

  assign bus.value = value;
  assign bus.tick  = tick_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed scoreboard bench for counter_ctrl (WIDTH = 8).
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    string      nm;
    logic [7:0] v;
    logic       t;
    logic       b;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  counter_ctrl_if #(.WIDTH(W)) bus ();

  counter_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.periodic = 1'b0; bus.limit = '0;
  end

  // Drive inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic r, s, sp, p, per, input logic [7:0] lim,
                      input string nm, input logic [7:0] v, input logic t, b, e);
    exp_t x;
    @(negedge clk);
    rst = r; bus.start = s; bus.stop = sp; bus.pause = p;
    bus.periodic = per; bus.limit = lim;
    x.nm = nm; x.v = v; x.t = t; x.b = b; x.e = e;
    sb.push_back(x);
  endtask

  task automatic idle(input string nm, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'd0, nm, 8'd0, 0, 0, 0);
  endtask

  // Monitor: every output cycle after a queued stimulus is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        n_checks++;
        if (bus.value === x.v && bus.tick === x.t && bus.busy === x.b && bus.err === x.e) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got value=%0d tick=%b busy=%b err=%b, want value=%0d tick=%b busy=%b err=%b",
                   x.nm, bus.value, bus.tick, bus.busy, bus.err, x.v, x.t, x.b, x.e);
        end
      end
    end
  end

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 8'd0, "reset", 8'd0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 8'd5, "reset_start", 8'd0, 0, 0, 0);

    // one-shot limit=3; later limit input changes must not matter
    step(0, 1, 0, 0, 0, 8'd3, "os_start", 8'd0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 8'd9, "os_1", 8'd1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd9, "os_2", 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd9, "os_3", 8'd3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd9, "os_tick", 8'd0, 1, 0, 0);
    idle("os_after", 2);

    // periodic limit=4, start mid-run ignored, stop at E+12
    step(0, 1, 0, 0, 1, 8'd4, "per_start", 8'd0, 0, 1, 0);
    for (int unsigned i = 1; i <= 4; i++)
      step(0, 0, 0, 0, 0, 8'd1, "per_a", 8'(i), 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd1, "per_tick1", 8'd0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 8'd1, "per_b1", 8'd1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'd0, "per_restart_ign", 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "per_b3", 8'd3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "per_b4", 8'd4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "per_tick2", 8'd0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "per_c1", 8'd1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'd0, "per_stop", 8'd0, 0, 0, 0);
    idle("per_no_tick", 3);

    // pause 3 cycles at value 2, limit=5 -> tick at E+9
    step(0, 1, 0, 0, 0, 8'd5, "pz_start", 8'd0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pz_1", 8'd1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pz_2", 8'd2, 0, 1, 0);
    for (int unsigned i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, 8'd0, "pz_hold", 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pz_3", 8'd3, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pz_4", 8'd4, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pz_5", 8'd5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pz_tick", 8'd0, 1, 0, 0);

    // pause on terminal cycle defers the tick
    step(0, 1, 0, 0, 0, 8'd2, "pt_start", 8'd0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pt_1", 8'd1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pt_2", 8'd2, 0, 1, 0);
    step(0, 0, 0, 1, 0, 8'd0, "pt_hold", 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "pt_tick", 8'd0, 1, 0, 0);

    // stop on terminal value: no tick
    step(0, 1, 0, 0, 1, 8'd1, "st_start", 8'd0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "st_1", 8'd1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'd0, "st_stop_term", 8'd0, 0, 0, 0);
    idle("st_after", 1);

    // stop while in HOLD
    step(0, 1, 0, 0, 0, 8'd3, "sh_start", 8'd0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 8'd0, "sh_hold", 8'd0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 8'd0, "sh_stop", 8'd0, 0, 0, 0);

    // zero limit and stop+start in IDLE
    step(0, 1, 0, 0, 0, 8'd0, "zero_err", 8'd0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 8'd0, "zero_err_clr", 8'd0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 8'd3, "stop_start_idle", 8'd0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 8'd0, "stop_start_zero", 8'd0, 0, 0, 0);
    idle("idle_quiet", 1);

    // reset mid-run at value 6, then a short run
    step(0, 1, 0, 0, 1, 8'd9, "rm_start", 8'd0, 0, 1, 0);
    for (int unsigned i = 1; i <= 6; i++)
      step(0, 0, 0, 0, 0, 8'd0, "rm_cnt", 8'(i), 0, 1, 0);
    step(1, 0, 0, 0, 0, 8'd0, "rm_reset", 8'd0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'd2, "rm_start2", 8'd0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "rm_1", 8'd1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "rm_2", 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, "rm_tick", 8'd0, 1, 0, 0);

    // full range periodic, limit=255: ticks 256 cycles apart
    step(0, 1, 0, 0, 1, 8'd255, "fr_start", 8'd0, 0, 1, 0);
    for (int unsigned k = 0; k < 2; k++) begin
      for (int unsigned i = 1; i <= 255; i++)
        step(0, 0, 0, 0, 0, 8'd0, "fr_cnt", 8'(i), 0, 1, 0);
      step(0, 0, 0, 0, 0, 8'd0, "fr_wrap_tick", 8'd0, 1, 1, 0);
    end
    step(0, 0, 1, 0, 0, 8'd0, "fr_stop", 8'd0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int unsigned guard;
    guard = 0;
    while (!stim_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    #2;
    if (!stim_done || sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: stim_done=%b pending=%0d, want stim_done=1 pending=0",
               stim_done, sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the counter and limit width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new count run; sampled only in IDLE.
REQ-005 stop  input  1  abort the current run and return to IDLE.
REQ-006 pause  input  1  level; freezes counting while high.
REQ-007 periodic  input  1  sampled with start: 1 = auto-reload, 0 = one-shot.
REQ-008 limit  input  WIDTH  terminal value, sampled with start.
REQ-009 value  output  WIDTH  current count, registered.
REQ-010 tick  output  1  one-cycle pulse, registered, marks terminal count reached.
REQ-011 busy  output  1  high in RUN or HOLD.
REQ-012 err  output  1  one-cycle pulse, registered, marks a rejected start.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, HOLD.
REQ-014 Per-edge priority SHALL be rst > stop > start-acceptance > pause > count.
REQ-015 IDLE + start + limit!=0 -> RUN; limit_q<=limit, periodic_q<=periodic, value<=0.
REQ-016 IDLE + start + limit==0 -> stay IDLE, err=1 for one cycle, value unchanged.
REQ-017 start outside IDLE SHALL be ignored: no err, no reload.
REQ-018 RUN, pause low, value!=limit_q: value<=value+1 each edge.
REQ-019 RUN, pause low, value==limit_q: value<=0, tick=1 next cycle; periodic_q=1 stays RUN, else -> IDLE.
REQ-020 First tick SHALL assert limit+1 edges after the start edge; periodic ticks SHALL repeat every limit+1 cycles.
REQ-021 RUN + pause high -> HOLD; HOLD holds value; HOLD + pause low -> RUN, counting on the next edge.
REQ-022 A terminal cycle with pause high SHALL enter HOLD without tick; tick fires after resume.
REQ-023 stop in RUN or HOLD -> IDLE, value<=0, no tick, even when value==limit_q.
REQ-024 stop in IDLE SHALL have no effect; stop+start in IDLE SHALL leave state IDLE, no err.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH; limit=2^WIDTH-1 gives a full-range period of 2^WIDTH cycles, no overflow.
REQ-026 limit and periodic changes after acceptance SHALL NOT affect the active run.
REQ-027 busy SHALL be a function of state only; tick and err SHALL default low every cycle.

Reset
REQ-028 On rst: state=IDLE, value=0, tick=0, err=0, busy=0, limit_q=0, periodic_q=0.
REQ-029 rst asserted mid-run SHALL abort at the next edge with no tick.
REQ-030 No asynchronous reset paths SHALL exist.

Structure
REQ-031 The state encoding (IDLE, RUN, HOLD) SHALL live in the shared counter package as a typedef with named constants.
REQ-032 The increment/clear datapath SHALL be one sub-module, count_core (ports: clk, rst, clr, en, value), instantiated once.
REQ-033 All outputs SHALL be registered; no combinational input-to-output paths.

Verification
REQ-034 One-shot: limit=3, periodic=0, start at edge E -> value 0,1,2,3,0; tick high only after edge E+4; busy drops the same cycle.
REQ-035 Periodic: limit=4, periodic=1 -> ticks at E+5, E+10, E+15; busy stays high; stop at E+12 -> value=0, IDLE, no tick at E+15.
REQ-036 Pause: limit=5, pause high for 3 cycles at value=2 -> value holds 2, first tick delayed 3 cycles to E+9.
REQ-037 Zero limit: start with limit=0 -> err one cycle, busy=0, value=0.
REQ-038 Reset mid-run: rst at value=6 with limit=9 -> all outputs reset next edge; later start with limit=2 -> tick at E+3.
REQ-039 Full range, WIDTH=8: limit=255, periodic=1 -> ticks exactly 256 cycles apart; value wraps 255->0.
